gig_eth_rx_frame_fifo: RTL

Store-and-forward frame buffer that sits directly downstream of the GbE MAC receive path, in the rx_clk domain. The MAC's RX AXIS stream has no tready and flags bad frames with tuser on the tlast beat. This block holds each frame until its tlast arrives. Good frames are committed and replayed on a back-pressurable AXIS master. Errored or overflowing frames are discarded in full, so downstream logic never sees a partial or bad frame.

---
 rtl/gig_eth_rx_frame_fifo.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/gig_eth_rx_frame_fifo.sv
// Store-and-forward RX frame buffer: holds MAC bytes until tlast, commits good frames,
// rolls back bad or overflowing ones, and replays committed bytes on a back-pressurable AXIS master.
module gig_eth_rx_frame_fifo #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic       rx_clk,
  input  logic       reset,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  input  logic       m_axis_tready,
  output logic       stat_good_frame,
  output logic       stat_bad_frame,
  output logic       stat_ovf_frame,
  output logic       dbg_wr_state_o
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] ptr_t;
  localparam ptr_t PTR_ONE   = ptr_t'(1);
  localparam ptr_t PTR_DEPTH = ptr_t'(DEPTH);

  typedef enum logic {ST_WRITE = 1'b0, ST_DROP = 1'b1} wr_state_t;

  wr_state_t  state_q, state_d;
  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       wr_commit_q, wr_commit_d;
  ptr_t       rd_ptr_q;
  logic       good_q, good_d;
  logic       bad_q, bad_d;
  logic       ovf_q, ovf_d;
  logic       wr_en;
  logic       full, empty;

  logic [8:0] mem [DEPTH];
  logic [8:0] ram_data_q;
  logic       ram_vld_q;
  logic       rd_issue, ram_move;
  logic [7:0] out_data_q;
  logic       out_last_q, out_vld_q;

  // full uses the pre-update rd_ptr, so it is conservative by one byte when a read issues this cycle.
  assign full  = (wr_ptr_q - rd_ptr_q) == PTR_DEPTH;
  assign empty = (rd_ptr_q == wr_commit_q);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    good_d      = 1'b0;
    bad_d       = 1'b0;
    ovf_d       = 1'b0;
    wr_en       = 1'b0;
    unique case (state_q)
      ST_WRITE: begin
        if (s_axis_tvalid) begin
          if (!full) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (s_axis_tlast && !s_axis_tuser) begin
              wr_commit_d = wr_ptr_q + PTR_ONE;
              good_d      = 1'b1;
            end else if (s_axis_tlast) begin
              wr_ptr_d = wr_commit_q;
              bad_d    = 1'b1;
            end
          end else begin
            wr_ptr_d = wr_commit_q;
            ovf_d    = 1'b1;
            if (!s_axis_tlast) state_d = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) state_d = ST_WRITE;
      end
      default: state_d = ST_WRITE;
    endcase
  end

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_WRITE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      ovf_q       <= ovf_d;
    end
  end

  // Reads only ever target committed bytes, so the read and write addresses never collide.
  always_ff @(posedge rx_clk) begin
    if (wr_en)    mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
    if (rd_issue) ram_data_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  end

  // Handshake: a beat transfers when m_axis_tvalid && m_axis_tready on a rising edge; once
  // tvalid is high, tvalid/tdata/tlast hold until that transfer. The input side has no ready.
  assign ram_move = ram_vld_q && (!out_vld_q || m_axis_tready);
  assign rd_issue = !empty && (!ram_vld_q || ram_move);

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      ram_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      if (rd_issue) begin
        rd_ptr_q  <= rd_ptr_q + PTR_ONE;
        ram_vld_q <= 1'b1;
      end else if (ram_move) begin
        ram_vld_q <= 1'b0;
      end
      if (ram_move) begin
        out_data_q <= ram_data_q[7:0];
        out_last_q <= ram_data_q[8];
        out_vld_q  <= 1'b1;
      end else if (m_axis_tready) begin
        out_vld_q  <= 1'b0;
      end
    end
  end

  assign m_axis_tdata    = out_data_q;
  assign m_axis_tlast    = out_last_q;
  assign m_axis_tvalid   = out_vld_q;
  assign m_axis_tuser    = 1'b0;
  assign stat_good_frame = good_q;
  assign stat_bad_frame  = bad_q;
  assign stat_ovf_frame  = ovf_q;
  assign dbg_wr_state_o  = state_q;

endmodule
